// File: rtl/regfile_multiport_sb.sv
// DEPTH x WIDTH register file: one synchronous write port, two async read ports, per-register pending bits.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module regfile_multiport_sb #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              busy1,
  output logic              busy2,
  output logic              all_idle
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;

  logic             w_wr_ok;
  logic             w_rsv_ok;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic             w_busy1;
  logic             w_busy2;

  // Addresses at or above DEPTH are silently ignored.
  assign w_wr_ok  = wr_en  && (32'(wr_addr)  < DEPTH);
  assign w_rsv_ok = rsv_en && (32'(rsv_addr) < DEPTH);

  // Storage and scoreboard; a same-edge reserve overrides the write's clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_wr_ok && (32'(wr_addr) == i)) begin
          r_mem[i]  <= wr_data;
          r_pend[i] <= 1'b0;
        end
        if (w_rsv_ok && (32'(rsv_addr) == i)) begin
          r_pend[i] <= 1'b1;
        end
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic w_rsv_same;
  assign w_rsv_same = rsv_en && (rsv_addr == wr_addr);
`endif

  // Read mux; out-of-range addresses fall through to data 0, busy 0.
  always_comb begin
    w_rd1   = '0;
    w_rd2   = '0;
    w_busy1 = 1'b0;
    w_busy2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(rd_addr1) == i) begin
        w_rd1   = r_mem[i];
        w_busy1 = r_pend[i];
      end
      if (32'(rd_addr2) == i) begin
        w_rd2   = r_mem[i];
        w_busy2 = r_pend[i];
      end
    end
`ifdef RF_BYPASS_EN
    if (w_wr_ok && (rd_addr1 == wr_addr)) begin
      w_rd1   = wr_data;
      w_busy1 = w_rsv_same;
    end
    if (w_wr_ok && (rd_addr2 == wr_addr)) begin
      w_rd2   = wr_data;
      w_busy2 = w_rsv_same;
    end
`endif
  end

  assign rd_data1 = w_rd1;
  assign rd_data2 = w_rd2;
  assign busy1    = w_busy1;
  assign busy2    = w_busy2;
  assign all_idle = ~|r_pend;

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Bench for regfile_multiport_sb (DEPTH=6): directed scenarios then random traffic vs. an array model.
module tb_regfile_multiport_sb;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 6;
  localparam int unsigned ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [WIDTH-1:0]  rd_data1;
  logic [WIDTH-1:0]  rd_data2;
  logic              busy1;
  logic              busy2;
  logic              all_idle;

  int n_vec = 0;
  int n_mis = 0;

  logic [WIDTH-1:0] m_reg  [8];
  logic             m_pend [8];

  always #5 clk = ~clk;

  regfile_multiport_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .busy1(busy1), .busy2(busy2), .all_idle(all_idle)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input int wa, input logic [WIDTH-1:0] wd,
                       input logic rv, input int ra, input int a1, input int a2);
    reset    = rst;
    wr_en    = we;
    wr_addr  = ADDR_W'(wa);
    wr_data  = wd;
    rsv_en   = rv;
    rsv_addr = ADDR_W'(ra);
    rd_addr1 = ADDR_W'(a1);
    rd_addr2 = ADDR_W'(a2);
  endtask

  // Expected read for one port from the array model plus the forwarding rule.
  task automatic model_read(input int a, output logic [WIDTH-1:0] d, output logic b);
    d = (a < int'(DEPTH)) ? m_reg[a] : '0;
    b = (a < int'(DEPTH)) ? m_pend[a] : 1'b0;
`ifdef RF_BYPASS_EN
    if (wr_en && int'(wr_addr) < int'(DEPTH) && a == int'(wr_addr)) begin
      d = wr_data;
      b = rsv_en && (rsv_addr == wr_addr);
    end
`endif
  endtask

  task automatic check_model(input string tag);
    logic [WIDTH-1:0] d1, d2;
    logic b1, b2, idle;
    #1;
    model_read(int'(rd_addr1), d1, b1);
    model_read(int'(rd_addr2), d2, b2);
    idle = 1'b1;
    for (int i = 0; i < 8; i++) if (m_pend[i]) idle = 1'b0;
    chk({tag, ".rd1"},  rd_data1, d1);
    chk({tag, ".rd2"},  rd_data2, d2);
    chk({tag, ".bsy1"}, WIDTH'(busy1), WIDTH'(b1));
    chk({tag, ".bsy2"}, WIDTH'(busy2), WIDTH'(b2));
    chk({tag, ".idle"}, WIDTH'(all_idle), WIDTH'(idle));
  endtask

  // Clock edge, then apply the same edge to the model.
  task automatic tick;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wr_en && int'(wr_addr) < int'(DEPTH)) begin
        m_reg[int'(wr_addr)]  = wr_data;
        m_pend[int'(wr_addr)] = 1'b0;
      end
      if (rsv_en && int'(rsv_addr) < int'(DEPTH)) m_pend[int'(rsv_addr)] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    drive(1'b1, 1'b1, 2, 32'h1111, 1'b1, 3, 0, 0);
    @(negedge clk);
    tick();

    // Reset state: every address reads zero and not busy.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 0, '0, 1'b0, 0, i, 7 - i);
      check_model("reset_rd");
      chk("reset_const_rd1", rd_data1, '0);
      chk("reset_const_idle", WIDTH'(all_idle), 32'd1);
      tick();
    end

    // Write r3, then read both ports.
    drive(1'b0, 1'b1, 3, 32'hDEADBEEF, 1'b0, 0, 3, 3);
    check_model("wr3_same");
    tick();
    drive(1'b0, 1'b0, 0, '0, 1'b0, 0, 3, 3);
    check_model("wr3_next");
    chk("wr3_const", rd_data2, 32'hDEADBEEF);
    tick();

    // Reserve r5, then write it to clear the pending bit.
    drive(1'b0, 1'b0, 0, '0, 1'b1, 5, 5, 0);
    check_model("rsv5");
    tick();
    drive(1'b0, 1'b1, 5, 32'h1234, 1'b0, 0, 5, 5);
    check_model("rsv5_busy");
    chk("rsv5_const_idle", WIDTH'(all_idle), 32'd0);
    tick();
    drive(1'b0, 1'b0, 0, '0, 1'b0, 0, 5, 3);
    check_model("wr5_clear");
    chk("wr5_const", rd_data1, 32'h1234);
    tick();

    // Write and reserve the same register: reserve wins.
    drive(1'b0, 1'b1, 2, 32'h55, 1'b1, 2, 2, 1);
    check_model("wr_rsv2");
    tick();
    drive(1'b0, 1'b0, 0, '0, 1'b0, 0, 2, 2);
    check_model("wr_rsv2_next");
    chk("wr_rsv2_const_busy", WIDTH'(busy1), 32'd1);
    tick();
    drive(1'b0, 1'b1, 2, 32'h66, 1'b0, 0, 2, 2);
    tick();

    // Out-of-range write and reserve leave everything untouched.
    drive(1'b0, 1'b1, 7, 32'hCAFE, 1'b1, 6, 7, 6);
    check_model("oor_same");
    tick();
    drive(1'b0, 1'b0, 0, '0, 1'b0, 0, 7, 6);
    check_model("oor_next");
    chk("oor_const_idle", WIDTH'(all_idle), 32'd1);
    tick();

    // Reset discards a concurrent write and reserve.
    drive(1'b1, 1'b1, 1, 32'hAA, 1'b1, 4, 1, 4);
    tick();
    drive(1'b0, 1'b0, 0, '0, 1'b0, 0, 1, 4);
    check_model("rst_mid");
    chk("rst_mid_const_busy", WIDTH'(busy2), 32'd0);
    tick();

    // Random traffic, including occasional resets and out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom), int'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      check_model("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
